// File: rtl/ahb_dma_pkg.sv
//------------------------------------------------------------------------------
// ahb_dma_pkg : shared AHB encodings and field widths for the DMA bus matrix
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ahb_dma_pkg;

  localparam int TRANS_W = 2;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 3;
  localparam int PROT_W  = 4;
  localparam int RESP_W  = 2;

  typedef enum logic [TRANS_W-1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [RESP_W-1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef struct packed {
    logic [TRANS_W-1:0] trans;
    logic               write;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
    logic [PROT_W-1:0]  prot;
    logic               mastlock;
  } ahb_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/ahb_dma_input_stage_if.sv
//------------------------------------------------------------------------------
// ahb_dma_input_stage_if : master-port bus, decoder feedback and decoder request
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ahb_dma_input_stage_if
  import ahb_dma_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic                HSELS;
  logic [ADDR_W-1:0]   HADDRS;
  logic [TRANS_W-1:0]  HTRANSS;
  logic                HWRITES;
  logic [SIZE_W-1:0]   HSIZES;
  logic [BURST_W-1:0]  HBURSTS;
  logic [PROT_W-1:0]   HPROTS;
  logic                HMASTLOCKS;
  logic                HREADYS;
  logic                active_dec;
  logic                readyout_dec;
  logic [RESP_W-1:0]   resp_dec;

  logic                sel_op;
  logic [ADDR_W-1:0]   addr_op;
  logic [TRANS_W-1:0]  trans_op;
  logic                write_op;
  logic [SIZE_W-1:0]   size_op;
  logic [BURST_W-1:0]  burst_op;
  logic [PROT_W-1:0]   prot_op;
  logic                mastlock_op;
  logic                held_tran_op;
  logic                HREADYOUTS;
  logic [RESP_W-1:0]   HRESPS;

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HREADYS, active_dec, readyout_dec, resp_dec,
    output sel_op, addr_op, trans_op, write_op, size_op, burst_op, prot_op,
           mastlock_op, held_tran_op, HREADYOUTS, HRESPS
  );

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HREADYS, active_dec, readyout_dec, resp_dec,
    input  sel_op, addr_op, trans_op, write_op, size_op, burst_op, prot_op,
           mastlock_op, held_tran_op, HREADYOUTS, HRESPS
  );

endinterface

`default_nettype wire

// File: rtl/ahb_dma_input_stage.sv
//------------------------------------------------------------------------------
// ahb_dma_input_stage : holds a master's address phase until its output stage
// grants it, and stalls the master until the held transfer's data phase ends.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ahb_dma_input_stage
  import ahb_dma_pkg::*;
#(
  parameter int ADDR_W = 32
)(
  input wire                    HCLK,
  input wire                    HRESETn,
  ahb_dma_input_stage_if.slave  bus
);

  ahb_ctrl_t           r_ctrl;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_pend;
  logic                r_dphase;

  ahb_ctrl_t           w_live;
  ahb_ctrl_t           w_ctrl;
  logic [ADDR_W-1:0]   w_addr;
  logic [TRANS_W-1:0]  w_trans_op;
  logic                w_new_tran;
  logic                w_err_abort;
  logic                w_readyout;
  logic [RESP_W-1:0]   w_resp;

  assign w_new_tran = bus.HSELS & bus.HREADYS & bus.HTRANSS[1];

  // First ERROR cycle with the master going IDLE: drop the held transfer.
  assign w_err_abort = r_pend & r_dphase & ~bus.readyout_dec &
                       (bus.resp_dec == HRESP_ERROR) &
                       (bus.HTRANSS == HTRANS_IDLE);

  always_comb begin
    w_live          = '0;
    w_live.trans    = bus.HTRANSS;
    w_live.write    = bus.HWRITES;
    w_live.size     = bus.HSIZES;
    w_live.burst    = bus.HBURSTS;
    w_live.prot     = bus.HPROTS;
    w_live.mastlock = bus.HMASTLOCKS;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_ctrl <= '0;
      r_addr <= '0;
    end else if (w_new_tran) begin
      r_ctrl <= w_live;
      r_addr <= bus.HADDRS;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pend   <= 1'b0;
      r_dphase <= 1'b0;
    end else begin
      if (w_new_tran & ~bus.active_dec)
        r_pend <= 1'b1;
      else if (bus.active_dec | w_err_abort)
        r_pend <= 1'b0;

      // An accept in the completing cycle starts the next data phase at once.
      if (bus.active_dec & w_trans_op[1])
        r_dphase <= 1'b1;
      else if (bus.readyout_dec)
        r_dphase <= 1'b0;
    end
  end

  assign w_ctrl = r_pend ? r_ctrl : w_live;
  assign w_addr = r_pend ? r_addr : bus.HADDRS;

  // A held beat may have lost the output stage, so it always restarts the burst.
  always_comb begin
    w_trans_op = w_ctrl.trans;
    if (r_pend && (r_ctrl.trans == HTRANS_SEQ))
      w_trans_op = HTRANS_NONSEQ;
  end

  always_comb begin
    w_readyout = 1'b1;
    w_resp     = HRESP_OKAY;
    if (r_pend & ~bus.active_dec)
      w_readyout = 1'b0;
    else if (r_dphase)
      w_readyout = bus.readyout_dec;
    if (r_dphase)
      w_resp = bus.resp_dec;
  end

  assign bus.sel_op       = r_pend | (bus.HSELS & bus.HREADYS);
  assign bus.addr_op      = w_addr;
  assign bus.trans_op     = w_trans_op;
  assign bus.write_op     = w_ctrl.write;
  assign bus.size_op      = w_ctrl.size;
  assign bus.burst_op     = w_ctrl.burst;
  assign bus.prot_op      = w_ctrl.prot;
  assign bus.mastlock_op  = w_ctrl.mastlock;
  assign bus.held_tran_op = r_pend;
  assign bus.HREADYOUTS   = w_readyout;
  assign bus.HRESPS       = w_resp;

endmodule

`default_nettype wire

// File: tb/tb_ahb_dma_input_stage.sv
//------------------------------------------------------------------------------
// tb_ahb_dma_input_stage : directed per-cycle vectors for the DMA input stage
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ahb_dma_input_stage;
  import ahb_dma_pkg::*;

  localparam int          ADDR_W = 32;
  localparam logic [2:0]  SIZE_C = 3'b010;
  localparam logic [3:0]  PROT_C = 4'b0011;
  localparam logic [31:0] A10 = 32'h2000_0010;
  localparam logic [31:0] A14 = 32'h2000_0014;
  localparam logic [31:0] A18 = 32'h2000_0018;
  localparam logic [31:0] A20 = 32'h2000_0020;
  localparam logic [31:0] A24 = 32'h2000_0024;
  localparam logic [31:0] A30 = 32'h2000_0030;
  localparam logic [31:0] A34 = 32'h2000_0034;
  localparam logic [31:0] AX  = 32'h3000_0000;
  localparam logic [1:0]  ID  = 2'b00;
  localparam logic [1:0]  BZ  = 2'b01;
  localparam logic [1:0]  NS  = 2'b10;
  localparam logic [1:0]  SQ  = 2'b11;
  localparam logic [1:0]  OK  = 2'b00;
  localparam logic [1:0]  ER  = 2'b01;

  typedef struct {
    string       name;
    logic        sel, ready;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  burst;
    logic        lock, act, rdy;
    logic [1:0]  resp;
    logic        e_sel, e_held;
    logic [1:0]  e_trans;
    logic [31:0] e_addr;
    logic        e_write;
    logic [2:0]  e_burst;
    logic        e_lock, e_hready;
    logic [1:0]  e_hresp;
  } vec_t;

  logic HCLK = 1'b0;
  logic HRESETn;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vq[$];

  ahb_dma_input_stage_if #(.ADDR_W(ADDR_W)) bus();

  ahb_dma_input_stage #(.ADDR_W(ADDR_W)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  function automatic vec_t mk(
    input string name, input logic sel, input logic ready, input logic [1:0] trans,
    input logic [31:0] addr, input logic write, input logic [2:0] burst, input logic lock,
    input logic act, input logic rdy, input logic [1:0] resp,
    input logic e_sel, input logic e_held, input logic [1:0] e_trans, input logic [31:0] e_addr,
    input logic e_write, input logic [2:0] e_burst, input logic e_lock, input logic e_hready,
    input logic [1:0] e_hresp);
    vec_t v;
    v.name = name; v.sel = sel; v.ready = ready; v.trans = trans; v.addr = addr;
    v.write = write; v.burst = burst; v.lock = lock; v.act = act; v.rdy = rdy; v.resp = resp;
    v.e_sel = e_sel; v.e_held = e_held; v.e_trans = e_trans; v.e_addr = e_addr;
    v.e_write = e_write; v.e_burst = e_burst; v.e_lock = e_lock;
    v.e_hready = e_hready; v.e_hresp = e_hresp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.HSELS        = v.sel;
    bus.HREADYS      = v.ready;
    bus.HTRANSS      = v.trans;
    bus.HADDRS       = v.addr;
    bus.HWRITES      = v.write;
    bus.HSIZES       = SIZE_C;
    bus.HBURSTS      = v.burst;
    bus.HPROTS       = PROT_C;
    bus.HMASTLOCKS   = v.lock;
    bus.active_dec   = v.act;
    bus.readyout_dec = v.rdy;
    bus.resp_dec     = v.resp;
  endtask

  task automatic check(input vec_t v);
    n_vec++;
    if (bus.sel_op !== v.e_sel || bus.held_tran_op !== v.e_held ||
        bus.trans_op !== v.e_trans || bus.addr_op !== v.e_addr ||
        bus.write_op !== v.e_write || bus.burst_op !== v.e_burst ||
        bus.mastlock_op !== v.e_lock || bus.size_op !== SIZE_C ||
        bus.prot_op !== PROT_C || bus.HREADYOUTS !== v.e_hready ||
        bus.HRESPS !== v.e_hresp) begin
      n_err++;
      $display("FAIL %s: got sel=%b held=%b trans=%b addr=%h wr=%b burst=%b lock=%b size=%b prot=%b rdy=%b resp=%b; want sel=%b held=%b trans=%b addr=%h wr=%b burst=%b lock=%b size=%b prot=%b rdy=%b resp=%b",
               v.name, bus.sel_op, bus.held_tran_op, bus.trans_op, bus.addr_op,
               bus.write_op, bus.burst_op, bus.mastlock_op, bus.size_op, bus.prot_op,
               bus.HREADYOUTS, bus.HRESPS, v.e_sel, v.e_held, v.e_trans, v.e_addr,
               v.e_write, v.e_burst, v.e_lock, SIZE_C, PROT_C, v.e_hready, v.e_hresp);
    end
  endtask

  // One bus cycle: drive just after the rising edge, sample at the falling edge.
  task automatic step(input vec_t v);
    @(posedge HCLK);
    #1;
    drive(v);
    @(negedge HCLK);
    check(v);
  endtask

  initial begin
    //           name      sel rdy trans addr wr burst lk act rdec resp | sel held trans addr wr burst lk hready hresp
    vq.push_back(mk("unc_accept", 1,1,NS,A10,0,3'b000,0, 1,1,OK, 1,0,NS,A10,0,3'b000,0,1,OK));
    vq.push_back(mk("unc_dwait",  0,0,ID,0,  0,3'b000,0, 0,0,OK, 0,0,ID,0,  0,3'b000,0,0,OK));
    vq.push_back(mk("unc_ddone",  0,1,ID,0,  0,3'b000,0, 0,1,OK, 0,0,ID,0,  0,3'b000,0,1,OK));
    vq.push_back(mk("unc_idle",   0,1,ID,0,  0,3'b000,0, 0,0,OK, 0,0,ID,0,  0,3'b000,0,1,OK));
    vq.push_back(mk("con_issue",  1,1,NS,A10,1,3'b000,1, 0,1,OK, 1,0,NS,A10,1,3'b000,1,1,OK));
    vq.push_back(mk("con_hold1",  1,0,ID,AX, 0,3'b000,0, 0,1,OK, 1,1,NS,A10,1,3'b000,1,0,OK));
    vq.push_back(mk("con_hold2",  1,0,ID,AX, 0,3'b000,0, 0,1,OK, 1,1,NS,A10,1,3'b000,1,0,OK));
    vq.push_back(mk("con_hold3",  1,0,ID,AX, 0,3'b000,0, 0,1,OK, 1,1,NS,A10,1,3'b000,1,0,OK));
    vq.push_back(mk("con_grant",  1,0,ID,AX, 0,3'b000,0, 1,1,OK, 1,1,NS,A10,1,3'b000,1,1,OK));
    vq.push_back(mk("slv_wait1",  0,0,ID,0,  0,3'b000,0, 0,0,OK, 0,0,ID,0,  0,3'b000,0,0,OK));
    vq.push_back(mk("slv_wait2",  0,0,ID,0,  0,3'b000,0, 0,0,OK, 0,0,ID,0,  0,3'b000,0,0,OK));
    vq.push_back(mk("slv_done",   0,1,ID,0,  0,3'b000,0, 0,1,OK, 0,0,ID,0,  0,3'b000,0,1,OK));
    vq.push_back(mk("seq_issue",  1,1,SQ,A14,0,3'b011,0, 0,1,OK, 1,0,SQ,A14,0,3'b011,0,1,OK));
    vq.push_back(mk("seq_held",   1,0,SQ,A18,0,3'b011,0, 0,1,OK, 1,1,NS,A14,0,3'b011,0,0,OK));
    vq.push_back(mk("seq_grant",  1,0,SQ,A18,0,3'b011,0, 1,1,OK, 1,1,NS,A14,0,3'b011,0,1,OK));
    vq.push_back(mk("seq_done",   0,0,ID,0,  0,3'b000,0, 0,1,OK, 0,0,ID,0,  0,3'b000,0,1,OK));
    vq.push_back(mk("busy_live",  1,1,BZ,32'h40,0,3'b001,0, 0,1,OK, 1,0,BZ,32'h40,0,3'b001,0,1,OK));
    vq.push_back(mk("idle_live",  1,1,ID,0,  0,3'b000,0, 0,0,OK, 1,0,ID,0,  0,3'b000,0,1,OK));
    vq.push_back(mk("no_pend",    0,1,ID,0,  0,3'b000,0, 0,0,OK, 0,0,ID,0,  0,3'b000,0,1,OK));

    HRESETn = 1'b0;
    drive(mk("rst", 0,1,ID,0,0,3'b000,0, 0,0,OK, 0,0,ID,0,0,3'b000,0,1,OK));
    #3;
    check(mk("reset_state", 0,1,ID,0,0,3'b000,0, 0,0,OK, 0,0,ID,0,0,3'b000,0,1,OK));
    repeat (2) @(posedge HCLK);
    #2;
    HRESETn = 1'b1;

    for (int i = 0; i < vq.size(); i++)
      step(vq[i]);

    // ERROR two-cycle response while a second transfer is held.
    step(mk("err_acc",   1,1,NS,A20,0,3'b000,0, 1,1,OK, 1,0,NS,A20,0,3'b000,0,1,OK));
    step(mk("err_queue", 1,1,NS,A24,0,3'b000,0, 0,0,OK, 1,0,NS,A24,0,3'b000,0,0,OK));
    step(mk("err_cyc1",  1,0,ID,0,  0,3'b000,0, 0,0,ER, 1,1,NS,A24,0,3'b000,0,0,ER));
    step(mk("err_cyc2",  0,0,ID,0,  0,3'b000,0, 0,1,ER, 0,0,ID,0,  0,3'b000,0,1,ER));
    step(mk("err_after", 0,1,ID,0,  0,3'b000,0, 0,0,ER, 0,0,ID,0,  0,3'b000,0,1,OK));

    // Asynchronous reset with pend and dphase both set.
    step(mk("rst_acc",   1,1,NS,A30,0,3'b000,1, 1,1,OK, 1,0,NS,A30,0,3'b000,1,1,OK));
    step(mk("rst_queue", 1,1,NS,A34,0,3'b000,1, 0,0,OK, 1,0,NS,A34,0,3'b000,1,0,OK));
    step(mk("rst_held",  1,0,ID,0,  0,3'b000,0, 0,0,OK, 1,1,NS,A34,0,3'b000,1,0,OK));
    #1;
    HRESETn = 1'b0;
    #1;
    check(mk("rst_async", 1,0,ID,0,0,3'b000,0, 0,0,OK, 0,0,ID,0,0,3'b000,0,1,OK));
    @(posedge HCLK);
    #2;
    HRESETn = 1'b1;
    step(mk("rst_norep1", 0,1,ID,0,0,3'b000,0, 0,0,OK, 0,0,ID,0,0,3'b000,0,1,OK));
    step(mk("rst_norep2", 0,1,ID,0,0,3'b000,0, 0,0,OK, 0,0,ID,0,0,3'b000,0,1,OK));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
